// File: rtl/scan_loader_if.sv
// Configuration-word handshake between a word source and the scan loader.
interface scan_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/scan_loader.sv
// Serialises configuration words MSB-first into a CHAIN_LEN-bit scan chain and
// returns the displaced chain bits as left-aligned readback words.
module scan_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              scan_clk,
    input  logic              rst,
    input  logic              start,
    scan_loader_if.slave      cfg,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);
    localparam int TOT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic              rd_valid_q, rd_valid_d;
    logic              scan_en_q, scan_en_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  idx_inc;
    logic [TOT_W-1:0]  total_inc;
    logic [WORD_W-1:0] rx_shift;
    logic              word_end;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        idx_d      = idx_q;
        total_d    = total_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        idx_inc   = idx_q + IDX_W'(1);
        total_inc = total_q + TOT_W'(1);
        rx_shift  = {rx_q[WORD_W-2:0], scan_out};
        word_end  = (idx_inc == IDX_LAST) || (total_inc == TOT_LAST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    total_d = '0;
                end
            end
            LOAD: begin
                if (cfg.cfg_valid && cfg_ready_q) begin
                    tx_d    = cfg.cfg_data;
                    rx_d    = '0;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                tx_d    = {tx_q[WORD_W-2:0], 1'b0};
                rx_d    = rx_shift;
                idx_d   = idx_inc;
                total_d = total_inc;
                if (word_end) begin
                    // Short final word: move its bits up so the first displaced bit is the MSB.
                    rd_data_d  = rx_shift << (IDX_LAST - idx_inc);
                    rd_valid_d = 1'b1;
                    state_d    = (total_inc == TOT_LAST) ? DONE : LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they never glitch.
        scan_en_d   = (state_d == SHIFT);
        cfg_ready_d = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge scan_clk) begin
        // NOTE: sequential state uses <= so every flop sees pre-edge values.
        if (rst) begin
            // NOTE: data buffers are cleared too, so scan_in and rd_data leave reset at 0.
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            rd_data_q   <= '0;
            idx_q       <= '0;
            total_q     <= '0;
            rd_valid_q  <= 1'b0;
            scan_en_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rd_data_q   <= rd_data_d;
            idx_q       <= idx_d;
            total_q     <= total_d;
            rd_valid_q  <= rd_valid_d;
            scan_en_q   <= scan_en_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign scan_en       = scan_en_q;
    assign scan_in       = tx_q[WORD_W-1];
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_scan_loader.sv
// Drives three scan_loader instances (16, 12 and 1 chain bits) against behavioural
// scan chains and a bit-stream reference model.
module tb_scan_loader;
    localparam int N = 3;
    localparam int W = 8;
    localparam int LEN [N] = '{16, 12, 1};

    logic scan_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 scan_clk = ~scan_clk;

    logic [N-1:0] start_v   = '0;
    logic [N-1:0] valid_v   = '0;
    logic [7:0]   data_v [N];
    logic [N-1:0] ready_v;
    logic [N-1:0] scan_en_v;
    logic [N-1:0] scan_in_v;
    logic [N-1:0] scan_out_v;
    logic [N-1:0] rd_valid_v;
    logic [N-1:0] busy_v;
    logic [N-1:0] done_v;
    logic [7:0]   rd_data_v [N];

    scan_loader_if #(.WORD_W(W)) if0 ();
    scan_loader_if #(.WORD_W(W)) if1 ();
    scan_loader_if #(.WORD_W(W)) if2 ();

    assign if0.cfg_data  = data_v[0];
    assign if0.cfg_valid = valid_v[0];
    assign ready_v[0]    = if0.cfg_ready;
    assign if1.cfg_data  = data_v[1];
    assign if1.cfg_valid = valid_v[1];
    assign ready_v[1]    = if1.cfg_ready;
    assign if2.cfg_data  = data_v[2];
    assign if2.cfg_valid = valid_v[2];
    assign ready_v[2]    = if2.cfg_ready;

    scan_loader #(.CHAIN_LEN(16), .WORD_W(W)) u_dut0 (
        .scan_clk(scan_clk), .rst(rst), .start(start_v[0]), .cfg(if0.slave),
        .scan_en(scan_en_v[0]), .scan_in(scan_in_v[0]), .scan_out(scan_out_v[0]),
        .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    scan_loader #(.CHAIN_LEN(12), .WORD_W(W)) u_dut1 (
        .scan_clk(scan_clk), .rst(rst), .start(start_v[1]), .cfg(if1.slave),
        .scan_en(scan_en_v[1]), .scan_in(scan_in_v[1]), .scan_out(scan_out_v[1]),
        .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    scan_loader #(.CHAIN_LEN(1), .WORD_W(W)) u_dut2 (
        .scan_clk(scan_clk), .rst(rst), .start(start_v[2]), .cfg(if2.slave),
        .scan_en(scan_en_v[2]), .scan_in(scan_in_v[2]), .scan_out(scan_out_v[2]),
        .rd_data(rd_data_v[2]), .rd_valid(rd_valid_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    // Behavioural chains: bit 0 is the head, bit LEN-1 the tail.
    logic [15:0]  chain [N];
    logic [N-1:0] preload_req = '0;
    logic [15:0]  preload_val [N];

    function automatic logic [15:0] mask(input int len);
        return 16'((32'd1 << len) - 32'd1);
    endfunction

    always @(posedge scan_clk) begin
        for (int i = 0; i < N; i++) begin
            if (preload_req[i])
                chain[i] <= preload_val[i];
            else if (scan_en_v[i])
                chain[i] <= ((chain[i] << 1) | 16'(scan_in_v[i])) & mask(LEN[i]);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_tail
        assign scan_out_v[g] = chain[g][LEN[g]-1];
    end

    // Event counters and readback log, sampled on the falling edge.
    int         en_cnt   [N];
    int         done_cnt [N];
    int         rd_cnt   [N];
    int         busy_cnt [N];
    logic [7:0] rd_log   [N][64];

    always @(negedge scan_clk) begin
        for (int i = 0; i < N; i++) begin
            if (scan_en_v[i]) en_cnt[i]++;
            if (done_v[i])    done_cnt[i]++;
            if (busy_v[i])    busy_cnt[i]++;
            if (rd_valid_v[i]) begin
                rd_log[i][rd_cnt[i] % 64] = rd_data_v[i];
                rd_cnt[i]++;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge scan_clk);
            #1;
        end
    endtask

    // Chain after a load: k-th bit of the MSB-first word stream lands at position LEN-1-k.
    function automatic logic [15:0] exp_chain(input int len, input logic [7:0] w0, input logic [7:0] w1);
        logic [15:0] stream;
        logic [15:0] r;
        stream = {w0, w1};
        r = '0;
        for (int k = 0; k < len; k++) r[len-1-k] = stream[15-k];
        return r;
    endfunction

    // Readback word j: displaced bits in tail-first order, left-aligned, zero padded.
    function automatic logic [7:0] exp_rd(input int len, input logic [15:0] old, input int j);
        logic [7:0] r;
        r = '0;
        for (int m = 0; m < W; m++)
            if (j * W + m < len) r[W-1-m] = old[len-1-(j*W+m)];
        return r;
    endfunction

    task automatic run_load(input int i, input logic [15:0] old, input logic [7:0] w0,
                            input logic [7:0] w1, input int stall, input bit restart);
        int         nw, b_en, b_done, b_rd, b_busy, t;
        logic [7:0] w [2];
        logic [15:0] old_m;
        nw    = (LEN[i] + W - 1) / W;
        w[0]  = w0;
        w[1]  = w1;
        old_m = old & mask(LEN[i]);

        preload_val[i] = old_m;
        preload_req[i] = 1'b1;
        step();
        preload_req[i] = 1'b0;

        b_en = en_cnt[i]; b_done = done_cnt[i]; b_rd = rd_cnt[i]; b_busy = busy_cnt[i];
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;

        for (int j = 0; j < nw; j++) begin
            t = 0;
            while (!ready_v[i] && t < 40) begin step(); t++; end
            if (t >= 40) check("ready_timeout", 32'd1, 32'd0);
            if (j > 0) begin
                for (int s = 0; s < stall; s++) begin
                    check("stall_ready", 32'(ready_v[i]), 32'd1);
                    check("stall_scan_en", 32'(scan_en_v[i]), 32'd0);
                    step();
                end
            end
            data_v[i]  = w[j];
            valid_v[i] = 1'b1;
            step();
            valid_v[i] = 1'b0;
            data_v[i]  = 8'($urandom);
            check("shift_ready", 32'(ready_v[i]), 32'd0);
            check("shift_en", 32'(scan_en_v[i]), 32'd1);
            if (restart && j == 0) begin
                start_v[i] = 1'b1;
                step();
                start_v[i] = 1'b0;
            end
        end

        t = 0;
        while (done_cnt[i] == b_done && t < 60) begin step(); t++; end
        if (t >= 60) check("done_timeout", 32'd1, 32'd0);
        step(2);

        check("chain", 32'(chain[i]), 32'(exp_chain(LEN[i], w0, w1)));
        check("scan_en_cycles", 32'(en_cnt[i] - b_en), 32'(LEN[i]));
        check("done_pulses", 32'(done_cnt[i] - b_done), 32'd1);
        check("rd_words", 32'(rd_cnt[i] - b_rd), 32'(nw));
        check("busy_cycles", 32'(busy_cnt[i] - b_busy), 32'(nw + LEN[i] + 1 + stall * (nw - 1)));
        for (int j = 0; j < nw; j++)
            check("rd_data", 32'(rd_log[i][(b_rd + j) % 64]), 32'(exp_rd(LEN[i], old_m, j)));
        check("idle_busy", 32'(busy_v[i]), 32'd0);
    endtask

    task automatic abort_then_reload();
        int b_rd, b_done;
        preload_val[0] = 16'($urandom);
        preload_req[0] = 1'b1;
        step();
        preload_req[0] = 1'b0;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        data_v[0]  = 8'($urandom);
        valid_v[0] = 1'b1;
        step();
        valid_v[0] = 1'b0;
        step(2);
        check("abort_in_shift", 32'(scan_en_v[0]), 32'd1);
        b_rd = rd_cnt[0]; b_done = done_cnt[0];
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_scan_en", 32'(scan_en_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_rd_valid", 32'(rd_valid_v[0]), 32'd0);
        check("abort_rd_data", 32'(rd_data_v[0]), 32'd0);
        step(12);
        check("abort_no_rd", 32'(rd_cnt[0] - b_rd), 32'd0);
        check("abort_no_done", 32'(done_cnt[0] - b_done), 32'd0);
        run_load(0, 16'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            data_v[i] = 8'hFF;
            preload_val[i] = '0;
        end
        // Reset must win over start and cfg_valid in the same cycle.
        start_v = '1;
        valid_v = '1;
        step(2);
        for (int i = 0; i < N; i++) begin
            check("rst_busy", 32'(busy_v[i]), 32'd0);
            check("rst_ready", 32'(ready_v[i]), 32'd0);
            check("rst_scan_en", 32'(scan_en_v[i]), 32'd0);
            check("rst_scan_in", 32'(scan_in_v[i]), 32'd0);
            check("rst_rd", {22'd0, rd_valid_v[i], done_v[i], rd_data_v[i]}, 32'd0);
        end
        rst     = 1'b0;
        start_v = '0;
        valid_v = '0;
        step(2);
        for (int i = 0; i < N; i++) check("idle_after_rst", 32'(busy_v[i]), 32'd0);

        run_load(0, 16'hA5C3, 8'h12, 8'h34, 0, 1'b0);
        run_load(1, 16'h0ABC, 8'hFF, 8'h50, 0, 1'b0);
        run_load(1, 16'h0ABC, 8'hFF, 8'h50, 5, 1'b0);
        run_load(0, 16'h5A3C, 8'h9E, 8'h61, 0, 1'b1);
        run_load(2, 16'h0001, 8'h00, 8'h00, 0, 1'b0);
        run_load(2, 16'h0000, 8'h80, 8'h00, 0, 1'b0);
        abort_then_reload();

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++)
                run_load(i, 16'($urandom), 8'($urandom), 8'($urandom),
                         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, total bits in the downstream scan chain (>= 1).
REQ-002 SHALL have parameter WORD_W, default 8, width of configuration and readback words (>= 2).
REQ-003 SHALL have port scan_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port cfg_data  input  WORD_W  next configuration word, MSB shifted first.
REQ-007 SHALL have port cfg_valid  input  1  cfg_data is valid.
REQ-008 SHALL have port cfg_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port scan_en  output  1  shift enable to the chain.
REQ-010 SHALL have port scan_in  output  1  serial data into the chain head.
REQ-011 SHALL have port scan_out  input  1  serial data from the chain tail.
REQ-012 SHALL have port rd_data  output  WORD_W  readback word of bits displaced from the chain.
REQ-013 SHALL have port rd_valid  output  1  single-cycle strobe for rd_data; no backpressure.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  single-cycle strobe when CHAIN_LEN bits have been shifted.

Function
REQ-016 SHALL implement states IDLE, LOAD, SHIFT and DONE, held in registers.
REQ-017 IDLE: start=1 -> LOAD next cycle, total bit counter cleared to 0; otherwise stay.
REQ-018 LOAD: cfg_ready=1 and scan_en=0; cfg_valid=1 -> capture cfg_data into the tx buffer, clear the per-word bit index, go to SHIFT.
REQ-019 cfg_ready SHALL be 0 in every state other than LOAD; handshake = cfg_valid & cfg_ready on the same edge.
REQ-020 SHIFT: scan_en=1 and scan_in = tx buffer MSB, both decoded from registers only (glitch-free); each cycle shift the tx buffer left by 1, increment the word index and the total counter.
REQ-021 SHIFT: on each cycle, shift scan_out (the chain-tail bit present before that edge) into the LSB of the rx buffer.
REQ-022 A word SHALL end after WORD_W SHIFT cycles, or earlier when the total counter reaches CHAIN_LEN (partial final word = CHAIN_LEN mod WORD_W bits, taken from the cfg_data MSBs; remaining cfg_data bits ignored).
REQ-023 At word end: total = CHAIN_LEN -> DONE; else -> LOAD.
REQ-024 rd_valid SHALL pulse for exactly one cycle in the cycle after each word end, with rd_data valid only in that cycle.
REQ-025 For a partial final word, rd_data SHALL be left-aligned (first displaced bit at MSB), with unused low bits 0.
REQ-026 DONE: done=1 for one cycle, then IDLE unconditionally.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 The total counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never exceed CHAIN_LEN.
REQ-029 scan_en SHALL be high for exactly CHAIN_LEN cycles per load, gaps allowed only while in LOAD.
REQ-030 Throughput: one word per WORD_W+1 cycles when cfg_valid is held high.

Reset
REQ-031 rst=1 SHALL force, on the next edge, state=IDLE, all counters and buffers=0, and outputs cfg_ready=0, scan_en=0, scan_in=0, rd_valid=0, rd_data=0, busy=0, done=0.
REQ-032 rst mid-SHIFT SHALL drop scan_en from the next cycle; no rd_valid or done for the aborted load; the chain contents are undefined until a full reload.
REQ-033 rst SHALL take priority over start and cfg_valid asserted in the same cycle.

Verification
REQ-034 CHAIN_LEN=16, WORD_W=8, 16-bit behavioural chain preloaded 0xA5C3; start, words 0x12 then 0x34 with cfg_valid held -> chain=0x1234, rd_data 0xA5 then 0xC3, exactly 16 scan_en cycles, one done pulse.
REQ-035 CHAIN_LEN=12, WORD_W=8, chain preloaded 0xABC; words 0xFF, 0x50 -> chain=0xFF5, rd_data 0xAB then 0xC0, second word shifts 4 bits, done once.
REQ-036 cfg_valid stalls 5 cycles between words -> scan_en=0 and cfg_ready=1 throughout the stall; final chain contents identical to the no-stall run.
REQ-037 start pulsed again during SHIFT -> no effect; scan_en count still CHAIN_LEN; single done.
REQ-038 rst asserted in the 3rd SHIFT cycle -> scan_en=0, busy=0 from the next cycle, no rd_valid or done; a subsequent full load completes correctly.
REQ-039 CHAIN_LEN=1 -> one word accepted, exactly 1 scan_en cycle, rd_data = {old bit, 0...}, done pulse.
